// File: rtl/mini_alu_core_pkg.sv
// -----------------------------------------------------------------------------
// mini_alu_core_pkg
// Shared definitions for the mini ALU core: opcode encoding, fixed field widths
// and the NOP opcode. Field positions depend on ADDR_W and are derived in the
// top from these widths.
// Instruction layout, MSB first: [op:OP_W][dst:ADDR_W][src1:ADDR_W][src0:ADDR_W]
// -----------------------------------------------------------------------------
package mini_alu_core_pkg;

  localparam int OP_W    = 4;  // opcode field width
  localparam int SHAMT_W = 4;  // shift amount taken from src0 register [3:0]
  localparam int LCD_W   = 8;  // LCD byte width

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_STO = 4'd3,
    OP_BLE = 4'd4,
    OP_JMP = 4'd5,
    OP_LED = 4'd6,
    OP_LCD = 4'd7,
    OP_AND = 4'd8,
    OP_OR  = 4'd9,
    OP_SHL = 4'd10,
    OP_SHR = 4'd11
  } opcode_e;

  // A whole instruction of zeros decodes as NOP; used for reset and flush.
  localparam logic [OP_W-1:0] NOP_OP = OP_NOP;

endpackage

// File: rtl/mini_alu_regfile.sv
// -----------------------------------------------------------------------------
// mini_alu_regfile
// Flop register file, 2**ADDR_W entries of DATA_W bits.
// Ports:
//   clk, rst_n             clock, asynchronous active-low clear of all entries
//   rd_addr_a / rd_data_a  combinational read port A
//   rd_addr_b / rd_data_b  combinational read port B
//   wr_en, wr_addr,        synchronous write port, takes effect at the edge
//   wr_data
// -----------------------------------------------------------------------------
module mini_alu_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/mini_alu_core.sv
// -----------------------------------------------------------------------------
// mini_alu_core
// Two-stage (fetch / execute) single-issue core. Fetches from an external
// combinational ROM, executes from a flop register file, drives an LED register
// and offers bytes on an LCD valid/ready channel.
// Ports:
//   Clock         rising-edge clock
//   Reset         asynchronous active-low reset
//   oIP           ROM address (instruction pointer)
//   iInstruction  ROM data, combinational from oIP
//   oLed          LED register
//   oLcdValid     LCD byte offered (LCD op in execute)
//   oLcdData      LCD byte = src1 register [7:0]
//   iLcdReady     LCD accepts the byte
// LCD handshake: oLcdValid is high for every cycle an LCD op sits in execute
// and oLcdData is held stable meanwhile; the byte transfers on the first edge
// with oLcdValid & iLcdReady. While oLcdValid & !iLcdReady the whole core
// holds (IP, execute register, register file, LED). iLcdReady is a don't-care
// when oLcdValid is low.
// -----------------------------------------------------------------------------
module mini_alu_core
  import mini_alu_core_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int IP_W   = 8,
  parameter int LED_W  = 8
) (
  input  logic                       Clock,
  input  logic                       Reset,
  output logic [IP_W-1:0]            oIP,
  input  logic [OP_W+3*ADDR_W-1:0]   iInstruction,
  output logic [LED_W-1:0]           oLed,
  output logic                       oLcdValid,
  output logic [LCD_W-1:0]           oLcdData,
  input  logic                       iLcdReady
);

  localparam int INSTR_W  = OP_W + 3*ADDR_W;
  localparam int SRC0_LSB = 0;
  localparam int SRC1_LSB = ADDR_W;
  localparam int DST_LSB  = 2*ADDR_W;
  localparam int OP_LSB   = 3*ADDR_W;

  logic [IP_W-1:0]    ip_q;
  logic [INSTR_W-1:0] ex_q;
  logic [LED_W-1:0]   led_q;

  // Execute-stage decode
  opcode_e             op;
  logic [ADDR_W-1:0]   dst;
  logic [ADDR_W-1:0]   src1;
  logic [ADDR_W-1:0]   src0;
  logic [2*ADDR_W-1:0] imm;
  logic [DATA_W-1:0]   a;  // src1 register
  logic [DATA_W-1:0]   b;  // src0 register

  assign op   = opcode_e'(ex_q[OP_LSB +: OP_W]);
  assign dst  = ex_q[DST_LSB  +: ADDR_W];
  assign src1 = ex_q[SRC1_LSB +: ADDR_W];
  assign src0 = ex_q[SRC0_LSB +: ADDR_W];
  assign imm  = {src1, src0};

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              led_we;
  logic              taken;
  logic [IP_W-1:0]   target;
  logic              lcd_op;
  logic              stall;

  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    led_we  = 1'b0;
    taken   = 1'b0;
    target  = '0;
    case (op)
      OP_ADD: begin wr_en = 1'b1; wr_data = a + b; end
      OP_SUB: begin wr_en = 1'b1; wr_data = a - b; end
      OP_STO: begin wr_en = 1'b1; wr_data = DATA_W'(imm); end
      OP_BLE: begin taken = (a <= b); target = IP_W'(dst); end
      OP_JMP: begin taken = 1'b1; target = IP_W'(imm); end
      OP_LED: led_we = 1'b1;
      OP_AND: begin wr_en = 1'b1; wr_data = a & b; end
      OP_OR:  begin wr_en = 1'b1; wr_data = a | b; end
      OP_SHL: begin wr_en = 1'b1; wr_data = a << b[SHAMT_W-1:0]; end
      OP_SHR: begin wr_en = 1'b1; wr_data = a >> b[SHAMT_W-1:0]; end
      default: ;  // NOP, LCD and the unused opcodes 12-15 have no ALU effect
    endcase
  end

  assign lcd_op = (op == OP_LCD);
  assign stall  = lcd_op & ~iLcdReady;

  // Only LCD can stall and it never writes, so the write enable needs no
  // stall qualification; it is gated anyway so a held cycle is side-effect free.
  mini_alu_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clk       (Clock),
    .rst_n     (Reset),
    .rd_addr_a (src1),
    .rd_data_a (a),
    .rd_addr_b (src0),
    .rd_data_b (b),
    .wr_en     (wr_en & ~stall),
    .wr_addr   (dst),
    .wr_data   (wr_data)
  );

  // A taken branch replaces the instruction fetched alongside it with NOP.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ip_q  <= '0;
      ex_q  <= '0;
      led_q <= '0;
    end else if (!stall) begin
      ip_q <= taken ? target : ip_q + IP_W'(1);
      ex_q <= taken ? {NOP_OP, {(3*ADDR_W){1'b0}}} : iInstruction;
      if (led_we) led_q <= a[LED_W-1:0];
    end
  end

  assign oIP       = ip_q;
  assign oLed      = led_q;
  assign oLcdValid = lcd_op;
  assign oLcdData  = a[LCD_W-1:0];

endmodule

// File: tb/tb_mini_alu_core.sv
module tb_mini_alu_core;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [7:0]  oIP;
  logic [15:0] iInstruction;
  logic [7:0]  oLed;
  logic        oLcdValid;
  logic [7:0]  oLcdData;
  logic        iLcdReady = 1'b1;

  logic [15:0] rom [256];
  int checks = 0;
  int errors = 0;

  assign iInstruction = rom[oIP];

  mini_alu_core #(
    .DATA_W (16),
    .ADDR_W (4),
    .IP_W   (8),
    .LED_W  (8)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .oIP          (oIP),
    .iInstruction (iInstruction),
    .oLed         (oLed),
    .oLcdValid    (oLcdValid),
    .oLcdData     (oLcdData),
    .iLcdReady    (iLcdReady)
  );

  // clock
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int d, input int s1, input int s0);
    enc = {op[3:0], d[3:0], s1[3:0], s0[3:0]};
  endfunction

  function automatic logic [15:0] sto(input int d, input int imm);
    sto = {4'd3, d[3:0], imm[7:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Architectural model: one instruction waiting to execute, the IP of the next
  // fetch, registers and LED. Checked on the falling edge, then advanced to what
  // the next rising edge must produce.
  // ---------------------------------------------------------------------------
  logic [7:0]  m_ip;
  logic [15:0] m_ex;
  logic [15:0] m_regs [16];
  logic [7:0]  m_led;
  logic [3:0]  m_op, m_d, m_s1, m_s0;
  logic [15:0] m_a, m_b;
  logic        m_jump;
  logic [7:0]  m_tgt;

  always @(negedge Clock) begin
    if (!Reset) begin
      m_ip  = 8'h00;
      m_ex  = 16'h0000;
      m_led = 8'h00;
      for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    end
    check("cyc_ip", {24'h0, oIP}, {24'h0, m_ip});
    check("cyc_led", {24'h0, oLed}, {24'h0, m_led});
    check("cyc_lcd_valid", {31'h0, oLcdValid}, {31'h0, (m_ex[15:12] == 4'd7)});
    if (m_ex[15:12] == 4'd7)
      check("cyc_lcd_data", {24'h0, oLcdData}, {24'h0, m_regs[m_ex[7:4]][7:0]});
    for (int i = 0; i < 16; i++)
      check($sformatf("cyc_reg%0d", i), {16'h0, dut.u_rf.mem[i]}, {16'h0, m_regs[i]});
    if (Reset) begin
      m_op = m_ex[15:12]; m_d = m_ex[11:8]; m_s1 = m_ex[7:4]; m_s0 = m_ex[3:0];
      m_a = m_regs[m_s1]; m_b = m_regs[m_s0];
      m_jump = 1'b0; m_tgt = 8'h00;
      if (!(m_op == 4'd7 && !iLcdReady)) begin
        case (m_op)
          4'd1:  m_regs[m_d] = m_a + m_b;
          4'd2:  m_regs[m_d] = m_a - m_b;
          4'd3:  m_regs[m_d] = {8'h00, m_s1, m_s0};
          4'd4:  if (m_a <= m_b) begin m_jump = 1'b1; m_tgt = {4'h0, m_d}; end
          4'd5:  begin m_jump = 1'b1; m_tgt = {m_s1, m_s0}; end
          4'd6:  m_led = m_a[7:0];
          4'd8:  m_regs[m_d] = m_a & m_b;
          4'd9:  m_regs[m_d] = m_a | m_b;
          4'd10: m_regs[m_d] = m_a << m_b[3:0];
          4'd11: m_regs[m_d] = m_a >> m_b[3:0];
          default: ;
        endcase
        m_ex = m_jump ? 16'h0000 : rom[m_ip];
        m_ip = m_jump ? m_tgt : m_ip + 8'd1;
      end
    end
  end

  // driver: advance n cycles, land 1 time unit after the rising edge
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = sto(1, 8'h05);
    rom[8'h01] = sto(2, 8'h03);
    rom[8'h02] = enc(1, 3, 2, 1);    // ADD r3 = r2 + r1
    rom[8'h03] = enc(6, 0, 3, 0);    // LED r3
    rom[8'h04] = enc(5, 0, 3, 0);    // JMP 0x30
    rom[8'h05] = sto(5, 8'hAA);      // flushed
    rom[8'h30] = sto(1, 8'h00);
    rom[8'h31] = sto(2, 8'h01);
    rom[8'h32] = enc(2, 3, 1, 2);    // SUB r3 = r1 - r2
    rom[8'h33] = enc(11, 4, 3, 2);   // SHR r4 = r3 >> r2
    rom[8'h34] = enc(4, 9, 1, 2);    // BLE r1<=r2 -> 9
    rom[8'h35] = sto(6, 8'hBB);      // flushed
    rom[8'h09] = sto(1, 8'h41);
    rom[8'h0A] = enc(7, 0, 1, 0);    // LCD r1
    rom[8'h0B] = sto(8, 8'h12);
    rom[8'h0C] = enc(1, 9, 8, 8);    // ADD r9 = r8 + r8
    rom[8'h0D] = enc(13, 10, 8, 8);  // illegal
    rom[8'h0E] = enc(1, 11, 9, 9);   // ADD r11 = r9 + r9
    rom[8'h0F] = enc(5, 0, 2, 0);    // JMP 0x20
    rom[8'h10] = sto(5, 8'hCC);      // flushed
    rom[8'h20] = enc(8, 12, 3, 1);   // AND r12 = r3 & r1
    rom[8'h21] = enc(9, 13, 8, 1);   // OR  r13 = r8 | r1
    rom[8'h22] = enc(10, 14, 1, 2);  // SHL r14 = r1 << r2
    rom[8'h23] = enc(4, 0, 3, 1);    // BLE not taken
    rom[8'h24] = sto(15, 8'h77);
    rom[8'h25] = enc(6, 0, 15, 0);   // LED r15
    rom[8'h26] = enc(7, 0, 13, 0);   // LCD r13
    rom[8'h27] = enc(7, 0, 1, 0);    // LCD r1
    rom[8'h28] = enc(5, 0, 2, 8);    // JMP 0x28

    Reset = 1'b0;
    iLcdReady = 1'b1;
    cycles(3);
    check("rst_ip", {24'h0, oIP}, 32'h0);
    check("rst_led", {24'h0, oLed}, 32'h0);
    check("rst_lcd_valid", {31'h0, oLcdValid}, 32'h0);
    Reset = 1'b1;

    cycles(4);
    check("led_before", {24'h0, oLed}, 32'h00);
    cycles(1);
    check("led_add", {24'h0, oLed}, 32'h08);
    cycles(1);
    check("jmp_ip_30", {24'h0, oIP}, 32'h30);
    cycles(4);
    check("sub_wrap", {16'h0, dut.u_rf.mem[3]}, 32'hFFFF);
    cycles(1);
    check("shr_logical", {16'h0, dut.u_rf.mem[4]}, 32'h7FFF);
    cycles(1);
    check("ble_taken_ip", {24'h0, oIP}, 32'h09);
    check("jmp_flush_r5", {16'h0, dut.u_rf.mem[5]}, 32'h0);
    cycles(1);
    check("ble_flush_r6", {16'h0, dut.u_rf.mem[6]}, 32'h0);
    iLcdReady = 1'b0;  // ignored: LCD not yet in execute
    for (int k = 0; k < 5; k++) begin
      cycles(1);
      check("stall_valid", {31'h0, oLcdValid}, 32'h1);
      check("stall_data", {24'h0, oLcdData}, 32'h41);
      check("stall_ip", {24'h0, oIP}, 32'h0B);
    end
    iLcdReady = 1'b1;
    cycles(1);
    check("lcd_done_ip", {24'h0, oIP}, 32'h0C);
    check("lcd_done_valid", {31'h0, oLcdValid}, 32'h0);
    cycles(3);
    check("add_r9", {16'h0, dut.u_rf.mem[9]}, 32'h24);
    check("illegal_r10", {16'h0, dut.u_rf.mem[10]}, 32'h0);
    cycles(2);
    check("jmp_ip_20", {24'h0, oIP}, 32'h20);
    check("add_r11", {16'h0, dut.u_rf.mem[11]}, 32'h48);
    check("illegal_led", {24'h0, oLed}, 32'h08);
    cycles(5);
    check("ble_nt_ip", {24'h0, oIP}, 32'h25);
    check("and_r12", {16'h0, dut.u_rf.mem[12]}, 32'h41);
    check("shl_r14", {16'h0, dut.u_rf.mem[14]}, 32'h82);
    cycles(2);
    check("led_r15", {24'h0, oLed}, 32'h77);
    check("lcd2_valid", {31'h0, oLcdValid}, 32'h1);
    check("lcd2_data", {24'h0, oLcdData}, 32'h53);
    cycles(1);
    check("lcd3_data", {24'h0, oLcdData}, 32'h41);
    iLcdReady = 1'b0;
    cycles(1);
    check("lcd3_stall_ip", {24'h0, oIP}, 32'h28);
    check("lcd3_stall_valid", {31'h0, oLcdValid}, 32'h1);
    #2;
    Reset = 1'b0;
    #1;
    check("midrst_valid", {31'h0, oLcdValid}, 32'h0);
    check("midrst_ip", {24'h0, oIP}, 32'h0);
    check("midrst_led", {24'h0, oLed}, 32'h0);
    cycles(1);
    for (int i = 0; i < 16; i++)
      check($sformatf("midrst_reg%0d", i), {16'h0, dut.u_rf.mem[i]}, 32'h0);
    Reset = 1'b1;
    iLcdReady = 1'b1;
    cycles(5);
    check("rerun_led", {24'h0, oLed}, 32'h08);
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
